trfir_stream: RTL

- Parametrised successor to the transposed-form FIR tap chain in the PE FoFIR datapath.
- Adds a valid/ready streaming handshake with backpressure and a double-buffered weight bank that is loaded per tap and committed atomically.
- Adds a flush/clear input, rounding right-shift with output saturation, and a sticky saturation flag.
- Sits between the activation feeder and the PE output collector.

---
 rtl/trfir_stream_if.sv | 33 +++
 rtl/trfir_stream.sv | 118 +++++++++++
 2 files changed

// File: rtl/trfir_stream_if.sv
// Stream, weight-load and control bundle of the transposed-form FIR tap chain.
// The master drives samples, weights and clear; the slave is the filter itself.
interface trfir_stream_if #(
    parameter int ACT_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int OUT_WIDTH    = 24,
    parameter int IDX_WIDTH    = 3
);
    logic                           in_valid;
    logic signed [ACT_WIDTH-1:0]    in_act;
    logic                           in_ready;
    logic                           out_valid;
    logic signed [OUT_WIDTH-1:0]    out_data;
    logic                           out_ready;
    logic                           w_load_valid;
    logic        [IDX_WIDTH-1:0]    w_load_idx;
    logic signed [WEIGHT_WIDTH-1:0] w_load_data;
    logic                           w_commit;
    logic                           clear;
    logic                           sat_flag;

    modport master (
        output in_valid, in_act, out_ready,
        output w_load_valid, w_load_idx, w_load_data, w_commit, clear,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_act, out_ready,
        input  w_load_valid, w_load_idx, w_load_data, w_commit, clear,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/trfir_stream.sv
// Transposed-form FIR tap chain with valid/ready streaming, double-buffered weights,
// rounding right-shift, output saturation and a sticky saturation flag.
module trfir_stream #(
    parameter int NB_TAPS      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACT_WIDTH    = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int OUT_WIDTH    = 24,
    parameter int OUT_SHIFT    = 0
) (
    input logic           clk,
    input logic           rst,
    trfir_stream_if.slave bus
);
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] HALF =
        (OUT_SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << RND_SH) : '0;

    // One extra bit so the rounding offset can never wrap the tap sum.
    function automatic logic signed [ACC_WIDTH:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [ACC_WIDTH:0] ext;
        ext = {v[ACC_WIDTH-1], v};
        return (ext + HALF) >>> OUT_SHIFT;
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_WIDTH:0] v);
        return !((&v[ACC_WIDTH:OUT_WIDTH-1]) || !(|v[ACC_WIDTH:OUT_WIDTH-1]));
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(
        input logic signed [ACC_WIDTH:0] v
    );
        if (!sat_hit(v))
            return v[OUT_WIDTH-1:0];
        else if (v[ACC_WIDTH])
            return {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        else
            return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    endfunction

    logic signed [WEIGHT_WIDTH-1:0] shadow     [NB_TAPS];
    logic signed [WEIGHT_WIDTH-1:0] shadow_nxt [NB_TAPS];
    logic signed [WEIGHT_WIDTH-1:0] active     [NB_TAPS];
    logic signed [ACC_WIDTH-1:0]    dly_p1     [1:NB_TAPS-1];
    logic signed [ACC_WIDTH-1:0]    prod       [NB_TAPS];
    logic signed [ACC_WIDTH-1:0]    tap        [NB_TAPS];
    logic signed [ACT_WIDTH-1:0]    act;
    logic signed [ACC_WIDTH-1:0]    x_ext;
    logic signed [ACC_WIDTH:0]      rnd;
    logic signed [OUT_WIDTH-1:0]    out_data_p1;
    logic                           vld_p1;
    logic                           sat_p1;
    logic                           stall;
    logic                           accept;

    assign stall        = vld_p1 && !bus.out_ready;
    assign bus.in_ready = !stall && !bus.clear;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = out_data_p1;
    assign bus.sat_flag  = sat_p1;

    // A load in the commit cycle must land in the committed bank, so both read this.
    always_comb begin
        shadow_nxt = shadow;
        if (bus.w_load_valid && (32'(bus.w_load_idx) < NB_TAPS))
            shadow_nxt[bus.w_load_idx] = bus.w_load_data;
    end

    always_comb begin
        act   = bus.in_act;
        x_ext = ACC_WIDTH'(act);
        for (int i = 0; i < NB_TAPS; i++)
            prod[i] = x_ext * ACC_WIDTH'(active[i]);
        tap[0] = prod[0];
        for (int i = 1; i < NB_TAPS; i++)
            tap[i] = prod[i] + dly_p1[i];
        rnd = round_shift(tap[NB_TAPS-1]);
    end

    // Stage p0 -> p1: tap sums into the delay line, rounded/saturated sum to the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB_TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            for (int i = 1; i < NB_TAPS; i++)
                dly_p1[i] <= '0;
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
            sat_p1      <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (bus.w_commit)
                active <= shadow_nxt;

            if (bus.clear) begin
                for (int i = 1; i < NB_TAPS; i++)
                    dly_p1[i] <= '0;
                vld_p1 <= 1'b0;
                sat_p1 <= 1'b0;
            end else if (accept) begin
                for (int i = 1; i < NB_TAPS; i++)
                    dly_p1[i] <= tap[i-1];
                out_data_p1 <= saturate(rnd);
                vld_p1      <= 1'b1;
                if (sat_hit(rnd))
                    sat_p1 <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end
endmodule
